// File: rtl/judge_pkg.sv
// Shared types and sizes for the plate character judge.
package judge_pkg;

  localparam int unsigned N_SLOTS  = 8;
  localparam int unsigned N_OUT    = 5;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DIFF_W   = 16;
  localparam int unsigned CONT_W   = 4;
  localparam int unsigned FRAMES_W = 8;

  localparam logic [IDX_W-1:0] BLANK_IDX = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } judge_state_e;

endpackage

// File: rtl/judge_frame_qualify.sv
// Combinational frame qualification: counts slots within the difference threshold
// and slices out the candidate characters (slots 7..3).
module judge_frame_qualify
  import judge_pkg::*;
(
  input  logic [N_SLOTS*IDX_W-1:0]  char_index,
  input  logic [N_SLOTS*DIFF_W-1:0] char_diff,
  input  logic [DIFF_W-1:0]         max_diff,
  output logic                      good,
  output logic [N_OUT*IDX_W-1:0]    cand
);

  logic [3:0] n_ok;
  logic       unused_low_idx;

  always_comb begin
    n_ok = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (char_diff[k*DIFF_W +: DIFF_W] <= max_diff) begin
        n_ok = n_ok + 4'd1;
      end
    end
  end

  assign good = (n_ok >= 4'(N_OUT));
  assign cand = char_index[N_SLOTS*IDX_W-1 -: N_OUT*IDX_W];

  // Trailing slots only feed the match count upstream, never the result.
  assign unused_low_idx = ^char_index[(N_SLOTS-N_OUT)*IDX_W-1:0];

endmodule

// File: rtl/plate_char_judge.sv
// Temporal-consistency judge: reports a 5-char plate result once the same
// qualified candidate is seen in enough consecutive frames.
module plate_char_judge
  import judge_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIFF_W-1:0]         max_diff,
  input  logic [CONT_W-1:0]         min_continue,
  input  logic [FRAMES_W-1:0]       min_counter,
  input  logic [N_SLOTS*IDX_W-1:0]  char_index_c,
  input  logic [N_SLOTS*DIFF_W-1:0] char_diff_c,
  input  logic                      char_valid_c,
  output logic [N_OUT*IDX_W-1:0]    char_index_co,
  output logic                      char_valid_co
);

  logic                   good_c;
  logic [N_OUT*IDX_W-1:0] cand_c;

  logic                   frame_q, good_q;
  logic [N_OUT*IDX_W-1:0] cand_q;

  judge_state_e           state_q, state_d;
  logic [N_OUT*IDX_W-1:0] stored_q, stored_d;
  logic [CONT_W-1:0]      cont_q, cont_d;
  logic [FRAMES_W-1:0]    frames_q, frames_d;
  logic [N_OUT*IDX_W-1:0] out_q, out_d;
  logic [CONT_W-1:0]      need;
  logic                   judge;

  judge_frame_qualify u_qualify (
    .char_index (char_index_c),
    .char_diff  (char_diff_c),
    .max_diff   (max_diff),
    .good       (good_c),
    .cand       (cand_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 1'b0;
      good_q  <= 1'b0;
      cand_q  <= '0;
    end else begin
      frame_q <= char_valid_c;
      if (char_valid_c) begin
        good_q <= good_c;
        cand_q <= cand_c;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    stored_d      = stored_q;
    cont_d        = cont_q;
    frames_d      = frames_q;
    out_d         = out_q;
    judge         = 1'b0;
    need          = (min_continue == '0) ? 4'd1 : min_continue;
    char_valid_co = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (frame_q && good_q) begin
          stored_d = cand_q;
          cont_d   = 4'd1;
          frames_d = 8'd1;
          judge    = 1'b1;
        end
      end
      COUNT: begin
        if (frame_q) begin
          if (frames_q != '1) frames_d = frames_q + 8'd1;
          // cont==0 marks a bad frame since the last load, forcing a reload
          if (!good_q) begin
            cont_d = '0;
          end else if (cont_q != '0 && cand_q == stored_q) begin
            if (cont_q != '1) cont_d = cont_q + 4'd1;
          end else begin
            stored_d = cand_q;
            cont_d   = 4'd1;
          end
          judge = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (judge) begin
      if (cont_d >= need) begin
        state_d = DONE;
        out_d   = stored_d;
      end else if (min_counter != '0 && frames_d >= min_counter) begin
        state_d = IDLE;
      end else begin
        state_d = COUNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stored_q <= '0;
      cont_q   <= '0;
      frames_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      stored_q <= stored_d;
      cont_q   <= cont_d;
      frames_q <= frames_d;
      out_q    <= out_d;
    end
  end

  assign char_index_co = out_q;

endmodule

// File: tb/tb_plate_char_judge.sv
// Self-checking bench for plate_char_judge: directed scenarios plus randomized
// frames compared every cycle against a frame-level behavioural model.
module tb_plate_char_judge;
  import judge_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  max_diff = 16'd30;
  logic [3:0]   min_continue = 4'd2;
  logic [7:0]   min_counter = 8'd0;
  logic [31:0]  char_index_c = '0;
  logic [127:0] char_diff_c = '0;
  logic         char_valid_c = 1'b0;
  logic [19:0]  char_index_co;
  logic         char_valid_co;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  localparam logic [127:0] D_GOOD = {{3{16'h00F0}}, {5{16'h0010}}};
  localparam logic [127:0] D_BAD  = {8{16'h0050}};

  plate_char_judge dut (
    .clk           (clk),
    .rst           (rst),
    .max_diff      (max_diff),
    .min_continue  (min_continue),
    .min_counter   (min_counter),
    .char_index_c  (char_index_c),
    .char_diff_c   (char_diff_c),
    .char_valid_c  (char_valid_c),
    .char_index_co (char_index_co),
    .char_valid_co (char_valid_co)
  );

  always #5 clk = ~clk;

  // Behavioural model: one frame in flight, one attempt tracked as plain integers.
  bit          m_pend = 0, m_good = 0, m_active = 0, m_done = 0;
  logic [19:0] m_cand = '0, m_stored = '0;
  int          m_run = 0, m_frames = 0;
  bit          exp_valid = 0;
  logic [19:0] exp_idx = '0;

  function automatic void model_frame();
    int need;
    need = (min_continue == 0) ? 1 : int'(min_continue);
    if (!m_active) begin
      if (!m_good) return;
      m_active = 1; m_stored = m_cand; m_run = 1; m_frames = 1;
    end else begin
      m_frames = (m_frames < 255) ? m_frames + 1 : 255;
      if (!m_good) m_run = 0;
      else if (m_run > 0 && m_cand == m_stored) m_run = (m_run < 15) ? m_run + 1 : 15;
      else begin m_stored = m_cand; m_run = 1; end
    end
    if (m_run >= need) begin
      m_done = 1; m_active = 0; exp_idx = m_stored;
    end else if (min_counter != 0 && m_frames >= int'(min_counter)) begin
      m_active = 0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0; m_good = 0; m_cand = '0; m_active = 0; m_done = 0;
      m_stored = '0; m_run = 0; m_frames = 0; exp_valid = 0; exp_idx = '0;
    end else begin
      int n;
      exp_valid = 0;
      if (m_done) m_done = 0;  // result cycle swallows any frame arriving now
      else if (m_pend) begin
        model_frame();
        exp_valid = m_done;
      end
      m_pend = char_valid_c;
      if (char_valid_c) begin
        n = 0;
        for (int k = 0; k < 8; k++) if (char_diff_c[k*16 +: 16] <= max_diff) n++;
        m_good = (n >= 5);
        m_cand = char_index_c[31:12];
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (char_valid_co !== exp_valid) begin
      errors++;
      $display("FAIL valid @%0t: got %0b expected %0b", $time, char_valid_co, exp_valid);
    end
    checks++;
    if (char_index_co !== exp_idx) begin
      errors++;
      $display("FAIL index @%0t: got %05h expected %05h", $time, char_index_co, exp_idx);
    end
    if (char_valid_co === 1'b1) pulse_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [19:0] top, input logic [127:0] d, input int gap);
    @(negedge clk);
    char_index_c = {top, 12'hAAA};
    char_diff_c  = d;
    char_valid_c = 1'b1;
    @(negedge clk);
    char_valid_c = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(char_valid_co), 32'd0);
    check("reset_index", 32'(char_index_co), 32'd0);
    rst = 1'b0;

    // 1: two identical good frames far apart
    base = pulse_cnt;
    send(20'h43210, D_GOOD, 50);
    check("t1_first_silent", 32'(pulse_cnt - base), 32'd0);
    send(20'h43210, D_GOOD, 5);
    check("t1_pulse", 32'(pulse_cnt - base), 32'd1);
    check("t1_index", 32'(char_index_co), 32'h43210);

    // 2: candidate change restarts the run
    base = pulse_cnt;
    send(20'h53210, D_GOOD, 4);
    send(20'h43210, D_GOOD, 4);
    check("t2_no_early", 32'(pulse_cnt - base), 32'd0);
    send(20'h43210, D_GOOD, 4);
    check("t2_pulse", 32'(pulse_cnt - base), 32'd1);
    check("t2_index", 32'(char_index_co), 32'h43210);

    // 3: bad frames never qualify
    base = pulse_cnt;
    for (int i = 0; i < 20; i++) send(20'(i * 7919), D_BAD, 2);
    check("t3_none", 32'(pulse_cnt - base), 32'd0);

    // 4: frame budget expires, then a clean run succeeds
    min_counter = 8'd3; min_continue = 4'd3;
    base = pulse_cnt;
    send(20'h43210, D_GOOD, 3);
    send(20'h53210, D_GOOD, 3);
    send(20'h43210, D_GOOD, 3);
    check("t4_budget", 32'(pulse_cnt - base), 32'd0);
    for (int i = 0; i < 3; i++) send(20'h43210, D_GOOD, 3);
    check("t4_pulse", 32'(pulse_cnt - base), 32'd1);
    check("t4_index", 32'(char_index_co), 32'h43210);

    // 5: min_continue=0, exact latency and width
    min_counter = 8'd0; min_continue = 4'd0;
    @(negedge clk);
    char_index_c = {20'h12345, 12'h000}; char_diff_c = D_GOOD; char_valid_c = 1'b1;
    @(negedge clk);
    char_valid_c = 1'b0;
    check("t5_lat_edge_n", 32'(char_valid_co), 32'd0);
    @(negedge clk);
    check("t5_lat_edge_n1", 32'(char_valid_co), 32'd1);
    check("t5_index", 32'(char_index_co), 32'h12345);
    @(negedge clk);
    check("t5_width", 32'(char_valid_co), 32'd0);
    check("t5_hold", 32'(char_index_co), 32'h12345);

    // 6: reset mid-attempt
    min_continue = 4'd3;
    send(20'h43210, D_GOOD, 2);
    send(20'h43210, D_GOOD, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(char_valid_co), 32'd0);
    check("t6_rst_index", 32'(char_index_co), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = pulse_cnt;
    send(20'h43210, D_GOOD, 4);
    check("t6_run_cleared", 32'(pulse_cnt - base), 32'd0);
    send(20'h43210, D_GOOD, 4);
    send(20'h43210, D_GOOD, 4);
    check("t6_restart", 32'(pulse_cnt - base), 32'd1);

    // Randomized phase, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if (c % 200 == 0) begin
        max_diff     = 16'($urandom_range(28, 32));
        min_continue = 4'($urandom_range(0, 4));
        case ($urandom_range(0, 2))
          0:       min_counter = 8'd0;
          1:       min_counter = 8'd3;
          default: min_counter = 8'd6;
        endcase
      end
      char_valid_c = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       char_index_c[31:12] = 20'h43210;
        1:       char_index_c[31:12] = 20'h53210;
        default: char_index_c[31:12] = 20'h4321A;
      endcase
      char_index_c[11:0] = 12'($urandom);
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: char_diff_c[k*16 +: 16] = 16'h0000;
          3, 4:    char_diff_c[k*16 +: 16] = max_diff;
          5:       char_diff_c[k*16 +: 16] = max_diff + 16'd1;
          default: char_diff_c[k*16 +: 16] = 16'hFFFF;
        endcase
      end
    end
    @(negedge clk);
    char_valid_c = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
